// File: rtl/reg_ring_master_pkg.sv
// Shared widths, state encodings and helpers for the register ring head controller.
package reg_ring_master_pkg;

  localparam int UDP_REG_ADDR_WIDTH  = 32;
  localparam int CPCI_NF2_DATA_WIDTH = 32;
  localparam logic [31:0] NO_ACK_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Ceiling log2, floored at 1 so the result can size a vector directly.
  function automatic int LOG2_FUNC(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < value) result = i + 1;
      else result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/reg_ring_master_rr_arbiter.sv
// Round-robin arbiter: searches from one past the last winner, pointer moves only on grant.
module rr_arbiter
  import reg_ring_master_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = LOG2_FUNC(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Rotating priority search; the pointer's own slot is checked last.
  always_comb begin
    int   k;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IDX_W'(k);
      end else begin
        found = found;
      end
    end
  end

  // Next pointer value.
  always_comb begin
    if (advance) ptr_d = gnt_idx;
    else         ptr_d = ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_ring_master.sv
// Head-of-ring register master: arbitrates local requesters, launches one ring
// transaction at a time, guards it with a timeout and reports the result.
module reg_ring_master
  import reg_ring_master_pkg::*;
#(
  parameter int NUM_REQ           = 2,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID            = 0,
  parameter int TIMEOUT_CYCLES    = 255,
  parameter logic [CPCI_NF2_DATA_WIDTH-1:0] NO_ACK_DATA = NO_ACK_DATA_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ-1:0]                     req_rd_wr_L,
  input  logic [NUM_REQ*UDP_REG_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*CPCI_NF2_DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                     done,
  output logic [CPCI_NF2_DATA_WIDTH-1:0]         rdata,
  output logic                                   err,
  output logic                                   reg_req_out,
  output logic                                   reg_ack_out,
  output logic                                   reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]          reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0]         reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]           reg_src_out,
  input  logic                                   reg_req_in,
  input  logic                                   reg_ack_in,
  input  logic                                   reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]          reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0]         reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]           reg_src_in
);

  localparam int AW    = UDP_REG_ADDR_WIDTH;
  localparam int DW    = CPCI_NF2_DATA_WIDTH;
  localparam int IDX_W = LOG2_FUNC(NUM_REQ);
  localparam int CNT_W = LOG2_FUNC(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic                   req_out_q, req_out_d;
  logic                   rd_wr_q, rd_wr_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DW-1:0]          data_q, data_d;
  logic [UDP_REG_SRC_WIDTH-1:0] src_q, src_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [NUM_REQ-1:0]     arb_gnt_s;
  logic [IDX_W-1:0]       arb_idx_s;
  logic                   advance_s;
  logic [AW-1:0]          sel_addr_s;
  logic [DW-1:0]          sel_data_s;
  logic                   sel_rd_s;
  logic                   unused_ring_s;

  // Only req/ack/data of the return matter; the rest of the echo is ignored.
  assign unused_ring_s = ^{reg_rd_wr_L_in, reg_addr_in, reg_src_in};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (advance_s),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s)
  );

  // Winning requester's fields, sampled only on the launch edge.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    sel_rd_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = arb_gnt_s[i] ? req_addr[i*AW +: AW]  : sel_addr_s;
      sel_data_s = arb_gnt_s[i] ? req_wdata[i*DW +: DW] : sel_data_s;
      sel_rd_s   = arb_gnt_s[i] ? req_rd_wr_L[i]        : sel_rd_s;
    end
  end

  // Transaction FSM, timeout counter and response capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_idx_d = gnt_idx_q;
    req_out_d = req_out_q;
    rd_wr_d   = rd_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    src_d     = src_q;
    done_d    = '0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    advance_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        // A stray return (late answer to an aborted launch) must clear before we launch.
        if (reg_req_in) begin
          state_d = ST_DRAIN;
        end else if (|req) begin
          state_d   = ST_ISSUE;
          advance_s = 1'b1;
          gnt_idx_d = arb_idx_s;
          cnt_d     = '0;
          req_out_d = 1'b1;
          rd_wr_d   = sel_rd_s;
          addr_d    = sel_addr_s;
          data_d    = sel_data_s;
          src_d     = UDP_REG_SRC_WIDTH'(SRC_ID);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (reg_req_in || (cnt_q == CNT_LIMIT)) begin
          state_d           = ST_DRAIN;
          done_d[gnt_idx_q] = 1'b1;
          req_out_d         = 1'b0;
          rd_wr_d           = 1'b0;
          addr_d            = '0;
          data_d            = '0;
          src_d             = '0;
          if (reg_req_in && reg_ack_in) begin
            err_d   = 1'b0;
            rdata_d = rd_wr_q ? reg_data_in : data_q;
          end else begin
            err_d   = 1'b1;
            rdata_d = NO_ACK_DATA;
          end
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (reg_req_in) state_d = ST_DRAIN;
        else            state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gnt_idx_q <= '0;
      req_out_q <= 1'b0;
      rd_wr_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      src_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_idx_q <= gnt_idx_d;
      req_out_q <= req_out_d;
      rd_wr_q   <= rd_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      src_q     <= src_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign done            = done_q;
  assign rdata           = rdata_q;
  assign err             = err_q;
  assign reg_req_out     = req_out_q;
  assign reg_ack_out     = 1'b0;
  assign reg_rd_wr_L_out = rd_wr_q;
  assign reg_addr_out    = addr_q;
  assign reg_data_out    = data_q;
  assign reg_src_out     = src_q;

endmodule

// File: tb/tb_reg_ring_master.sv
// Directed bench for reg_ring_master with a hand-driven ring slave and TIMEOUT_CYCLES=16.
module tb_reg_ring_master;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  req_rd_wr_L;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        err;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [31:0] reg_addr_out, reg_data_out;
  logic [1:0]  reg_src_out;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [31:0] reg_addr_in, reg_data_in;
  logic [1:0]  reg_src_in;

  int errors = 0;
  int checks = 0;

  reg_ring_master #(
    .NUM_REQ(2), .UDP_REG_SRC_WIDTH(2), .SRC_ID(0),
    .TIMEOUT_CYCLES(16), .NO_ACK_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_rd_wr_L(req_rd_wr_L),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req_out(input string tag, output int n);
    n = 0;
    while (reg_req_out !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 64'(reg_req_out), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; req = 2'b00; req_rd_wr_L = 2'b00; req_addr = 64'd0; req_wdata = 64'd0;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = 32'd0; reg_data_in = 32'd0; reg_src_in = 2'd0;
    tick(); tick();
    chk("rst_req_out", 64'(reg_req_out), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr_out", 64'(reg_addr_out), 64'd0);
    reset = 1'b1;
    tick();

    // Single read from requester 0, slave acks after a short ring.
    req_addr[31:0] = 32'h0200_0708; req_rd_wr_L = 2'b01; req = 2'b01;
    tick();
    chk("t1_req_out", 64'(reg_req_out), 64'd1);
    chk("t1_addr_out", 64'(reg_addr_out), 64'h0200_0708);
    chk("t1_rdwr_out", 64'(reg_rd_wr_L_out), 64'd1);
    chk("t1_src_out", 64'(reg_src_out), 64'd0);
    chk("t1_ack_out", 64'(reg_ack_out), 64'd0);
    tick(); tick();
    chk("t1_held", 64'(reg_addr_out), 64'h0200_0708);
    reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_data_in = 32'h1234_5678;
    chk("t1_no_early_done", 64'(done), 64'd0);
    tick();
    chk("t1_done", 64'(done), 64'b01);
    chk("t1_rdata", 64'(rdata), 64'h1234_5678);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_req_out_drop", 64'(reg_req_out), 64'd0);
    req = 2'b00; reg_req_in = 1'b0; reg_ack_in = 1'b0;
    tick();
    chk("t1_done_pulse", 64'(done), 64'd0);
    tick();

    // Write from requester 1 to an unmapped address: no ack.
    req_addr[63:32] = 32'h0000_0040; req_wdata[63:32] = 32'hCAFE_F00D;
    req_rd_wr_L = 2'b00; req = 2'b10;
    tick();
    chk("t2_req_out", 64'(reg_req_out), 64'd1);
    chk("t2_addr_out", 64'(reg_addr_out), 64'h40);
    chk("t2_data_out", 64'(reg_data_out), 64'hCAFE_F00D);
    chk("t2_rdwr_out", 64'(reg_rd_wr_L_out), 64'd0);
    reg_req_in = 1'b1; reg_ack_in = 1'b0; reg_data_in = 32'hCAFE_F00D;
    tick();
    chk("t2_done", 64'(done), 64'b10);
    chk("t2_err", 64'(err), 64'd1);
    chk("t2_rdata", 64'(rdata), 64'hDEAD_BEEF);
    req = 2'b00; reg_req_in = 1'b0;
    tick();
    chk("t2_done_once", 64'(done), 64'd0);
    tick();

    // Both requesters held: grants alternate 0,1,0,1 with DRAIN+GAP between launches.
    req_addr = {32'h0000_0200, 32'h0000_0100}; req_rd_wr_L = 2'b11; req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_req_out("t3_issue", n);
      if (t > 0) chk("t3_spacing", 64'(n), 64'd2);
      chk("t3_order", 64'(reg_addr_out), (t % 2 == 0) ? 64'h100 : 64'h200);
      reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_data_in = 32'hA0 + 32'(t);
      tick();
      chk("t3_done", 64'(done), (t % 2 == 0) ? 64'b01 : 64'b10);
      chk("t3_rdata", 64'(rdata), 64'hA0 + 64'(t));
      chk("t3_no_overlap", 64'(reg_req_out), 64'd0);
      reg_req_in = 1'b0; reg_ack_in = 1'b0;
      if (t == 3) req = 2'b00;
    end
    tick(); tick();

    // Timeout: no return, done exactly 16 cycles after launch; late return absorbed.
    req_addr[31:0] = 32'h0000_0300; req_rd_wr_L = 2'b01; req = 2'b01;
    wait_req_out("t4_issue", n);
    repeat (15) tick();
    chk("t4_no_done_yet", 64'(done), 64'd0);
    chk("t4_still_out", 64'(reg_req_out), 64'd1);
    tick();
    chk("t4_done", 64'(done), 64'b01);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_rdata", 64'(rdata), 64'hDEAD_BEEF);
    chk("t4_req_out_drop", 64'(reg_req_out), 64'd0);
    req = 2'b00;
    repeat (4) tick();
    reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_data_in = 32'h0000_0077;
    req_addr[63:32] = 32'h0000_0400; req_rd_wr_L = 2'b10; req = 2'b10;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_late_no_done", 64'(done), 64'd0);
      chk("t4_late_no_grant", 64'(reg_req_out), 64'd0);
    end
    reg_req_in = 1'b0; reg_ack_in = 1'b0;
    tick();
    chk("t4_gap", 64'(reg_req_out), 64'd0);
    tick();
    chk("t4_next_grant", 64'(reg_req_out), 64'd1);
    chk("t4_next_addr", 64'(reg_addr_out), 64'h400);

    // Return arrives in the same cycle the counter hits its limit: return wins.
    repeat (15) tick();
    reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_data_in = 32'h55AA_55AA;
    tick();
    chk("t5_done", 64'(done), 64'b10);
    chk("t5_err", 64'(err), 64'd0);
    chk("t5_rdata", 64'(rdata), 64'h55AA_55AA);
    reg_req_in = 1'b0; reg_ack_in = 1'b0;

    // Reset in the middle of ISSUE, pointer last at 1: after release req[1] wins.
    wait_req_out("t6_issue", n);
    tick();
    reset = 1'b0;
    #1;
    chk("t6_async_req_out", 64'(reg_req_out), 64'd0);
    chk("t6_async_addr", 64'(reg_addr_out), 64'd0);
    chk("t6_async_rdata", 64'(rdata), 64'd0);
    chk("t6_async_done", 64'(done), 64'd0);
    chk("t6_async_err", 64'(err), 64'd0);
    req_addr[31:0] = 32'h0000_0500; req_rd_wr_L = 2'b11; req = 2'b11;
    tick(); tick();
    chk("t6_held_done", 64'(done), 64'd0);
    reset = 1'b1;
    tick();
    chk("t6_regrant", 64'(reg_req_out), 64'd1);
    chk("t6_first_is_1", 64'(reg_addr_out), 64'h400);
    reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_data_in = 32'h0000_0011;
    tick();
    chk("t6_done", 64'(done), 64'b10);
    req = 2'b00; reg_req_in = 1'b0; reg_ack_in = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_ring_master.md
# reg_ring_master

Head-of-ring controller for the UDP register ring. It arbitrates round-robin among `NUM_REQ` local requesters, such as the CPU bridge and a stats poller. It injects one transaction at a time onto the ring (`reg_*_out`) and waits for the transaction to return on `reg_*_in`. A timeout guards every transaction, and the block reports completion, read data and error status back to the granted requester. It sits upstream of every ring slave module in the user datapath register chain.

## Interface
- `NUM_REQ`, 2: number of local requesters (2..8).
- `UDP_REG_SRC_WIDTH`, 2: width of `reg_src_*`.
- `SRC_ID`, 0: value driven on `reg_src_out`.
- `TIMEOUT_CYCLES`, 255: cycles to wait for a return before aborting (1..65535).
- `NO_ACK_DATA`, 32'hDEAD_BEEF: data reported on a no-ack or timeout.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request level; held high until that requester's `done`.
- `req_rd_wr_L`  in  NUM_REQ  1 = read, 0 = write.
- `req_addr`  in  NUM_REQ*`UDP_REG_ADDR_WIDTH`  flattened; requester i occupies slice i.
- `req_wdata`  in  NUM_REQ*`CPCI_NF2_DATA_WIDTH`  flattened write data.
- `done`  out  NUM_REQ  one-cycle completion pulse, one-hot.
- `rdata`  out  `CPCI_NF2_DATA_WIDTH`  valid when any `done` is high.
- `err`  out  1  valid with `done`; 1 = no ack or timeout.
- `reg_req_out`, `reg_ack_out`, `reg_rd_wr_L_out`, `reg_addr_out`, `reg_data_out`, `reg_src_out`  out  1/1/1/`UDP_REG_ADDR_WIDTH`/`CPCI_NF2_DATA_WIDTH`/`UDP_REG_SRC_WIDTH`  ring outputs.
- `reg_req_in`, `reg_ack_in`, `reg_rd_wr_L_in`, `reg_addr_in`, `reg_data_in`, `reg_src_in`  in  same widths  ring return.

## Operation
- States:
  - IDLE: wait for any `req` bit.
  - ISSUE: transaction is on the ring.
  - DRAIN: wait for the ring return to clear.
  - GAP: one-cycle spacer.
- IDLE → ISSUE when any `req` bit is high; the round-robin arbiter picks the winner and its index is registered as `gnt_idx`.
- ISSUE:
  - Drive `reg_req_out=1`, `reg_ack_out=0`, `reg_src_out=SRC_ID`, plus the granted requester's address, data and rd_wr_L.
  - Hold all ring outputs stable until leaving ISSUE.
  - The timeout counter counts from 0.
- ISSUE → DRAIN on `reg_req_in=1`, with the return sampled that cycle:
  - `reg_ack_in=1` gives `err=0`; `rdata=reg_data_in` for a read, or the written data echoed for a write.
  - `reg_ack_in=0` gives `err=1`, `rdata=NO_ACK_DATA`.
- ISSUE → DRAIN on `count == TIMEOUT_CYCLES-1` with no return: `err=1`, `rdata=NO_ACK_DATA`.
- `done[gnt_idx]` pulses in the cycle after the return or timeout is detected. The same edge deasserts `reg_req_out`.
- DRAIN → GAP once `reg_req_in=0`. A late return of an aborted transaction is absorbed here and never reported.
- GAP → IDLE after one cycle. All ring outputs are zero in GAP, IDLE and DRAIN.
- Arbitration:
  - The pointer starts at 0.
  - Search begins at `last_gnt+1` and wraps modulo `NUM_REQ`.
  - The pointer updates only on grant.
  - Simultaneous requests are resolved by the pointer.
  - A requester that drops `req` before grant is simply not seen; dropping it after grant has no effect on the transaction.
- Requester fields are sampled at the IDLE → ISSUE edge only.
- The block never overlaps transactions: at most one request is outstanding on the ring.

## Timing
- Reset (asynchronous assert, synchronous release by `clk`): state=IDLE, pointer=0, counter=0, and every output 0, including `done`, `rdata`, `err` and all `reg_*_out`.
- `req` rising in cycle N gives `reg_req_out=1` in N+1.
- Return in cycle M gives `done` and `reg_req_out=0` in M+1.
- The earliest next `reg_req_out` is M+3, after DRAIN (≥1 cycle) and GAP (1 cycle).
- Timeout: `done` fires exactly `TIMEOUT_CYCLES` cycles after `reg_req_out` rose.
- If `reg_req_in` rises in the same cycle the counter reaches its limit, the return wins and the response is used.
- Reset asserted mid-transaction drops `reg_req_out` immediately and produces no `done`.
- Counter width is clog2(`TIMEOUT_CYCLES`+1). It saturates and never wraps.

## Structure
- Shared include:
  - state encodings (2-bit: IDLE=0, ISSUE=1, DRAIN=2, GAP=3)
  - the `NO_ACK_DATA` default
  - `LOG2_FUNC`, already standard in the codebase
- One sub-module, `rr_arbiter` (parameter `NUM_REQ`; in `req`, `advance`; out one-hot `gnt`, binary `gnt_idx`), holding the rotating pointer.
- The FSM, counter and response capture are in the top level.

## Test plan
- Single read, req[0], addr 0x2000708, slave acks with 0x12345678 after a 3-cycle ring → `done[0]` at return+1, `rdata` = 0x12345678, `err` = 0.
- `req` = 2'b11 held continuously for 4 transactions → grant order 0,1,0,1; ring `reg_req_out` pulses never overlap, with ≥1 GAP cycle between them.
- Write to an unmapped address, returning ack = 0 → `err` = 1, `rdata` = 0xDEADBEEF, `done[gnt]` pulses once.
- `TIMEOUT_CYCLES` = 16, no return → `done` exactly 16 cycles after `reg_req_out` rose, `err` = 1. A late return at +20 produces no `done` and delays the next grant until `reg_req_in` falls.
- Return and timeout in the same cycle → `err` = 0 with the returned data.
- `reset` low in the middle of ISSUE → all outputs 0 asynchronously; after release, req[1] pending is granted first, since the pointer is back at 0 and the search begins at 1.
